// File: rtl/dump_sched.sv
// Dump scheduler: round-robin arbitration of tx/rx dump requests and sequencing of
// the dump-on handshake, with a dump-on timeout, a post-dump holdoff and sticky errors.
module dump_sched #(
  parameter int HOLDOFF = 8,
  parameter int TIMEOUT = 64
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       req_tx,
  input  logic       req_rx,
  input  logic       dump_on,
  input  logic       clr_err,
  output logic       state_start,
  output logic [1:0] gnt,
  output logic       done_tx,
  output logic       done_rx,
  output logic       busy,
  output logic       err_ovr,
  output logic       err_to
);

  typedef enum logic [2:0] {IDLE, START, WAIT_ON, WAIT_OFF, HOLD} state_t;

  localparam logic [7:0] TO_LIM   = 8'(TIMEOUT);
  localparam logic [7:0] HOLD_LIM = 8'(HOLDOFF);

  state_t     state, state_nx;
  logic [1:0] pend, pend_nx;
  logic [1:0] gnt_q, gnt_nx;
  logic [1:0] win, grant, req;
  logic       last_rx, last_rx_nx;
  logic [7:0] cnt, cnt_nx;
  logic       ovr_set, to_set;

  assign req = {req_rx, req_tx};

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    win = pend;
    if (pend == 2'b11) win = last_rx ? 2'b01 : 2'b10;
  end

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt_q;
    cnt_nx      = cnt;
    last_rx_nx  = last_rx;
    grant       = 2'b00;
    state_start = 1'b0;
    done_tx     = 1'b0;
    done_rx     = 1'b0;
    to_set      = 1'b0;
    case (state)
      IDLE: begin
        if (win != 2'b00) begin
          grant      = win;
          gnt_nx     = win;
          last_rx_nx = win[1];
          state_nx   = START;
        end
      end
      START: begin
        state_start = 1'b1;
        cnt_nx      = 8'd1;
        state_nx    = WAIT_ON;
      end
      WAIT_ON: begin
        if (dump_on) begin
          state_nx = WAIT_OFF;
        end else if (cnt >= TO_LIM) begin
          to_set   = 1'b1;
          gnt_nx   = 2'b00;
          cnt_nx   = 8'd1;
          state_nx = HOLD;
        end else if (cnt != 8'hFF) begin
          cnt_nx = cnt + 8'd1;
        end
      end
      WAIT_OFF: begin
        if (!dump_on) begin
          done_tx  = gnt_q[0];
          done_rx  = gnt_q[1];
          gnt_nx   = 2'b00;
          cnt_nx   = 8'd1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (cnt >= HOLD_LIM) begin
          cnt_nx   = 8'd0;
          state_nx = IDLE;
        end else if (cnt != 8'hFF) begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A request hitting an already-set pend is dropped and flagged.
  assign pend_nx = (pend | req) & ~grant;
  assign ovr_set = |(req & pend);

  // While idle the grant follows the arbiter so the winner is visible a cycle early.
  assign gnt  = (state == IDLE) ? win : gnt_q;
  assign busy = (state != IDLE);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend    <= 2'b00;
      gnt_q   <= 2'b00;
      last_rx <= 1'b1;
      cnt     <= 8'd0;
      err_ovr <= 1'b0;
      err_to  <= 1'b0;
    end else begin
      state   <= state_nx;
      pend    <= pend_nx;
      gnt_q   <= gnt_nx;
      last_rx <= last_rx_nx;
      cnt     <= cnt_nx;
      err_ovr <= ovr_set | (err_ovr & ~clr_err);
      err_to  <= to_set | (err_to & ~clr_err);
    end
  end

endmodule
